// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared helpers for the memory request arbiter and its ID FIFO.
//   port_idx_width() : bits needed to name one master port (at least 1)
//   PERF_CNT_WIDTH   : width of every optional performance counter
// The request bundle type depends on module parameters, so it is declared
// inside mem_req_arbiter as req_t.
package mem_arb_pkg;

    localparam int PERF_CNT_WIDTH = 32;

    function automatic int port_idx_width(input int nr_ports);
        int w;
        w = $clog2(nr_ports);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// mem_arb_id_fifo
// In-order FIFO holding the index of the master behind each in-flight request.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (flushes the FIFO)
//   push_i, din_i write din_i at the tail (ignored while full)
//   pop_i         drop the head entry (ignored while empty)
//   full_o        count == DEPTH
//   empty_o       count == 0
//   head_o        oldest entry, valid while !empty_o
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    // DEPTH == 1 still gets a 1-bit pointer; the count keeps occupancy at one
    // entry, so wrapping over two slots stays correct.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [SLOTS];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= din_i;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Round-robin arbiter of NR_PORTS req/gnt/rvalid masters onto one slave port.
// In-order responses are routed back through an ID FIFO of the granted ports.
// Ports:
//   clk_i, rst_i                        clock, asynchronous active-high reset
//   m_req_i/m_addr_i/m_we_i/m_be_i/m_wdata_i  per-master request bundle
//   m_gnt_o, m_rvalid_o                 per-master grant and response valid
//   m_rdata_o                           shared response data (qualify with m_rvalid_o)
//   s_req_o/s_addr_o/s_we_o/s_be_o/s_wdata_o  slave request bundle
//   s_gnt_i, s_rvalid_i, s_rdata_i      slave grant and response
//   err_o                               sticky: response seen with nothing in flight
// Handshake: a request transfers in the cycle where s_req_o & s_gnt_i; the
// grant is passed combinationally to the winning master in that same cycle.
// Every transferred request gets exactly one s_rvalid_i, in order, at least
// one cycle after its grant.
// Optional build macro MEM_REQ_ARBITER_PERF_EN adds perf_stall_o and
// perf_grant_o saturating counters.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NR_PORTS        = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NR_PORTS-1:0]                     m_req_i,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NR_PORTS-1:0]                     m_we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]   m_be_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]     m_wdata_i,
    output logic [NR_PORTS-1:0]                     m_gnt_o,
    output logic [NR_PORTS-1:0]                     m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                   m_rdata_o,
    output logic                                    s_req_o,
    output logic [ADDR_WIDTH-1:0]                   s_addr_o,
    output logic                                    s_we_o,
    output logic [DATA_WIDTH/8-1:0]                 s_be_o,
    output logic [DATA_WIDTH-1:0]                   s_wdata_o,
    input  logic                                    s_gnt_i,
    input  logic                                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                   s_rdata_i,
`ifdef MEM_REQ_ARBITER_PERF_EN
    output logic [PERF_CNT_WIDTH-1:0]               perf_stall_o,
    output logic [NR_PORTS-1:0][PERF_CNT_WIDTH-1:0] perf_grant_o,
`endif
    output logic                                    err_o
);

    localparam int IDX_W = port_idx_width(NR_PORTS);
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic [IDX_W-1:0] r_rr_ptr;
    logic             r_err;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_any_req;
    logic             w_hs;
    logic             w_pop;
    req_t             w_sel;

    // Scan ports starting at the pointer; the sum stays below 2*NR_PORTS so
    // one conditional subtract performs the wrap.
    always_comb begin
        logic [IDX_W:0] v_sum;
        logic           v_found;
        w_winner = '0;
        v_found  = 1'b0;
        v_sum    = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (v_sum >= (IDX_W+1)'(NR_PORTS)) v_sum = v_sum - (IDX_W+1)'(NR_PORTS);
            if (!v_found && m_req_i[v_sum[IDX_W-1:0]]) begin
                v_found  = 1'b1;
                w_winner = v_sum[IDX_W-1:0];
            end
        end
    end

    assign w_sel.addr  = m_addr_i[w_winner];
    assign w_sel.we    = m_we_i[w_winner];
    assign w_sel.be    = m_be_i[w_winner];
    assign w_sel.wdata = m_wdata_i[w_winner];

    assign s_addr_o  = w_sel.addr;
    assign s_we_o    = w_sel.we;
    assign s_be_o    = w_sel.be;
    assign s_wdata_o = w_sel.wdata;

    // Gating with rst_i keeps the slave quiet while reset is held even if
    // masters keep requesting. Full blocks requests regardless of a pop in
    // the same cycle.
    assign w_any_req = |m_req_i;
    assign s_req_o   = ~rst_i & w_any_req & ~w_full;
    assign w_hs      = s_req_o & s_gnt_i;
    assign w_pop     = ~rst_i & s_rvalid_i & ~w_empty;

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (w_hs)  m_gnt_o[w_winner]  = 1'b1;
        if (w_pop) m_rvalid_o[w_head] = 1'b1;
    end

    assign m_rdata_o = s_rdata_i;
    assign err_o     = r_err;

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_hs),
        .din_i   (w_winner),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_rr_ptr <= (w_winner == IDX_W'(NR_PORTS-1)) ? '0 : w_winner + 1'b1;
            end
            if (s_rvalid_i && w_empty) r_err <= 1'b1;
        end
    end

`ifdef MEM_REQ_ARBITER_PERF_EN
    logic [PERF_CNT_WIDTH-1:0]               r_perf_stall;
    logic [NR_PORTS-1:0][PERF_CNT_WIDTH-1:0] r_perf_grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_stall <= '0;
            r_perf_grant <= '0;
        end else begin
            if (w_any_req && (!s_gnt_i || w_full) && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            for (int i = 0; i < NR_PORTS; i++) begin
                if (m_gnt_o[i] && (r_perf_grant[i] != '1)) begin
                    r_perf_grant[i] <= r_perf_grant[i] + 1'b1;
                end
            end
        end
    end

    assign perf_stall_o = r_perf_stall;
    assign perf_grant_o = r_perf_grant;
`endif

endmodule
